// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, state encoding and direction helpers for the snake step controller
//
// Purpose: one place for the direction one-hot codes, the FSM state
// encoding, the reset body geometry and the direction helper functions.
// Ports: none (package).

package snake_pkg;

    // Direction one-hot codes, bit order {down, up, left, right}.
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    localparam int         LEN_W        = 5;
    localparam logic [7:0] RESET_HEAD_X = 8'h40;
    localparam logic [7:0] RESET_HEAD_Y = 8'h40;
    localparam logic [4:0] RESET_LEN    = 5'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_MOVE   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    // Reduce a possibly multi-hot button vector to one direction,
    // priority left > right > up > down.
    function automatic logic [3:0] pick_dir(input logic [3:0] btn);
        if (btn[1]) return DIR_LEFT;
        if (btn[0]) return DIR_RIGHT;
        if (btn[2]) return DIR_UP;
        if (btn[3]) return DIR_DOWN;
        return DIR_NONE;
    endfunction

    // Opposite direction: swaps right<->left and up<->down.
    function automatic logic [3:0] opposite_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// rtl/snake_step_ctrl_if.sv - control, display-read and status signals of the snake step controller
//
// Purpose: bundles the game controls (start, btn_dir, food), the body read
// port (rd_idx -> rd_x/rd_y) and the status outputs into one interface.
// Modports: master drives start/btn_dir/food_x/food_y/rd_idx and observes
// the rest; slave (the controller) is the reverse.

interface snake_step_ctrl_if;
    logic       start;
    logic [3:0] btn_dir;
    logic [7:0] food_x;
    logic [7:0] food_y;
    logic [3:0] rd_idx;
    logic [7:0] rd_x;
    logic [7:0] rd_y;
    logic [7:0] head_x;
    logic [7:0] head_y;
    logic [4:0] length;
    logic [2:0] state;
    logic       game_over;
    logic       step_done;
    logic       food_eaten;

    modport master (
        output start, btn_dir, food_x, food_y, rd_idx,
        input  rd_x, rd_y, head_x, head_y, length, state, game_over, step_done, food_eaten
    );

    modport slave (
        input  start, btn_dir, food_x, food_y, rd_idx,
        output rd_x, rd_y, head_x, head_y, length, state, game_over, step_done, food_eaten
    );
endinterface

// File: rtl/step_timer.sv
// rtl/step_timer.sv - tick counter that paces one snake step
//
// Purpose: counts enabled cycles 0..STEP_CYCLES-1 and flags the last one.
// Ports: clk, rst (async, active-high); en counts; clr forces the count to 0;
// done is high during the enabled cycle holding the final count.

module step_timer #(
    parameter int STEP_CYCLES = 6_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam logic [23:0] LAST = 24'(STEP_CYCLES - 1);

    logic [23:0] cnt_q;

    assign done = en && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 24'd0;
        end else if (clr) begin
            cnt_q <= 24'd0;
        end else if (en) begin
            cnt_q <= done ? 24'd0 : cnt_q + 24'd1;
        end
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// rtl/snake_step_ctrl.sv - snake game step controller: body buffer, heading and step FSM
//
// Purpose: waits STEP_CYCLES per step, computes the next head from the
// heading (with at most one buffered turn), checks walls in MOVE, checks
// self-collision one segment per cycle in SCAN and shifts the body in COMMIT.
// Ports: clk, rst (async, active-high); bus (slave modport): start, btn_dir,
// food_x/food_y, rd_idx in; rd_x/rd_y, head_x/head_y, length, state,
// game_over, step_done, food_eaten out.

module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int         STEP_CYCLES = 6_000_000,
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] GRID_MAX    = 8'd127
) (
    input  logic               clk,
    input  logic               rst,
    snake_step_ctrl_if.slave   bus
);

    localparam int              IDX_W     = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t            state_q, state_d;

    logic [7:0]        seg_x [MAX_LEN];
    logic [7:0]        seg_y [MAX_LEN];
    logic [7:0]        init_x [MAX_LEN];
    logic [7:0]        init_y [MAX_LEN];
    logic [LEN_W-1:0]  len_q;
    logic [3:0]        heading_q;
    logic [3:0]        pending_q;
    logic [7:0]        nx_q, ny_q;
    logic              grow_q, eat_q;
    logic [IDX_W-1:0]  scan_idx_q;
    logic              step_done_q, food_eaten_q;

    logic              tmr_en, tmr_clr, tmr_done;
    logic              capture_en, restart, over_c;

    logic [3:0]        heading_eff, ref_dir, req;
    logic              req_ok;
    logic [7:0]        mv_x, mv_y;
    logic              wall_hit, food_hit, scan_hit, scan_end;
    logic [LEN_W-1:0]  scan_last;
    logic [IDX_W-1:0]  rd_sel;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (tmr_en),
        .clr  (tmr_clr),
        .done (tmr_done)
    );

    // Reset body image: head at RESET_HEAD, remaining initial segments trailing to the left.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            init_x[i] = 8'd0;
            init_y[i] = 8'd0;
        end
        for (int i = 0; i < int'(RESET_LEN); i++) begin
            init_x[i] = RESET_HEAD_X - 8'(i);
            init_y[i] = RESET_HEAD_Y;
        end
    end

    // The buffered turn takes effect in MOVE; this is the heading used for that step.
    assign heading_eff = (pending_q != DIR_NONE) ? pending_q : heading_q;

    // In MOVE the heading is being replaced, so a new request is judged against the new heading.
    assign ref_dir = (state_q == ST_MOVE) ? heading_eff : heading_q;
    assign req     = pick_dir(bus.btn_dir);
    assign req_ok  = (req != DIR_NONE) && (req != ref_dir) && (req != opposite_dir(ref_dir));

    always_comb begin
        mv_x = seg_x[0];
        mv_y = seg_y[0];
        case (heading_eff)
            DIR_RIGHT: mv_x = seg_x[0] + 8'd1;
            DIR_LEFT:  mv_x = seg_x[0] - 8'd1;
            DIR_UP:    mv_y = seg_y[0] - 8'd1;
            DIR_DOWN:  mv_y = seg_y[0] + 8'd1;
            default:   ;
        endcase
    end

    assign wall_hit = (mv_x == 8'd0) || (mv_x >= GRID_MAX) || (mv_y == 8'd0) || (mv_y >= GRID_MAX);
    assign food_hit = (mv_x == bus.food_x) && (mv_y == bus.food_y);

    // Without growth the tail cell is vacated this step, so it is excluded from the scan.
    assign scan_last = grow_q ? len_q - LEN_W'(1) : len_q - LEN_W'(2);
    assign scan_hit  = (seg_x[scan_idx_q] == nx_q) && (seg_y[scan_idx_q] == ny_q);
    assign scan_end  = (LEN_W'(scan_idx_q) == scan_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_WAIT;
            ST_WAIT:   if (tmr_done) state_d = ST_MOVE;
            ST_MOVE:   state_d = wall_hit ? ST_OVER : ST_SCAN;
            ST_SCAN: begin
                if (scan_hit) begin
                    state_d = ST_OVER;
                end else if (scan_end) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_WAIT;
            ST_OVER:   if (bus.start) state_d = ST_WAIT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        tmr_en     = 1'b0;
        tmr_clr    = 1'b1;
        capture_en = 1'b0;
        restart    = 1'b0;
        over_c     = 1'b0;
        case (state_q)
            ST_IDLE:   restart = bus.start;
            ST_WAIT: begin
                tmr_en     = 1'b1;
                tmr_clr    = 1'b0;
                capture_en = 1'b1;
            end
            ST_MOVE,
            ST_SCAN,
            ST_COMMIT: capture_en = 1'b1;
            ST_OVER: begin
                over_c  = 1'b1;
                restart = bus.start;
            end
            default:   ;
        endcase
    end

    // Body, heading and step datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x[i];
                seg_y[i] <= init_y[i];
            end
            len_q        <= RESET_LEN;
            heading_q    <= DIR_RIGHT;
            pending_q    <= DIR_NONE;
            nx_q         <= 8'd0;
            ny_q         <= 8'd0;
            grow_q       <= 1'b0;
            eat_q        <= 1'b0;
            scan_idx_q   <= '0;
            step_done_q  <= 1'b0;
            food_eaten_q <= 1'b0;
        end else begin
            step_done_q  <= (state_q == ST_COMMIT);
            food_eaten_q <= (state_q == ST_COMMIT) && eat_q;

            if (restart) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    seg_x[i] <= init_x[i];
                    seg_y[i] <= init_y[i];
                end
                len_q     <= RESET_LEN;
                heading_q <= DIR_RIGHT;
                pending_q <= DIR_NONE;
                grow_q    <= 1'b0;
                eat_q     <= 1'b0;
            end else begin
                if (state_q == ST_MOVE) begin
                    heading_q  <= heading_eff;
                    pending_q  <= req_ok ? req : DIR_NONE;
                    nx_q       <= mv_x;
                    ny_q       <= mv_y;
                    eat_q      <= food_hit;
                    grow_q     <= food_hit && (len_q < MAX_LEN_L);
                    scan_idx_q <= '0;
                end else if (capture_en && req_ok) begin
                    pending_q <= req;
                end

                if (state_q == ST_SCAN) begin
                    scan_idx_q <= scan_idx_q + 1'b1;
                end

                if (state_q == ST_COMMIT) begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= nx_q;
                    seg_y[0] <= ny_q;
                    if (grow_q) begin
                        len_q <= len_q + LEN_W'(1);
                    end
                end
            end
        end
    end

    assign rd_sel         = bus.rd_idx[IDX_W-1:0];
    assign bus.rd_x       = ({1'b0, bus.rd_idx} < len_q) ? seg_x[rd_sel] : 8'd0;
    assign bus.rd_y       = ({1'b0, bus.rd_idx} < len_q) ? seg_y[rd_sel] : 8'd0;
    assign bus.head_x     = seg_x[0];
    assign bus.head_y     = seg_y[0];
    assign bus.length     = len_q;
    assign bus.state      = state_q;
    assign bus.game_over  = over_c;
    assign bus.step_done  = step_done_q;
    assign bus.food_eaten = food_eaten_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb/tb_snake_step_ctrl.sv - randomized self-checking bench for snake_step_ctrl against a queue-based game model

module tb_snake_step_ctrl;

    localparam int STEP = 8;
    localparam int MAXL = 16;
    localparam int GMAX = 127;

    logic clk = 1'b0;
    logic rst;

    always #20 clk = ~clk;

    snake_step_ctrl_if bus();

    snake_step_ctrl #(
        .STEP_CYCLES (STEP),
        .MAX_LEN     (MAXL),
        .GRID_MAX    (8'd127)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Game model: body as a queue of cells, head at the front.
    // Headings: 0 right, 1 left, 2 up, 3 down; opposite is code^1.
    typedef struct {
        int x;
        int y;
    } cell_t;

    cell_t body[$];
    int    heading;

    function automatic int dx(input int h);
        return (h == 0) ? 1 : (h == 1) ? -1 : 0;
    endfunction

    function automatic int dy(input int h);
        return (h == 2) ? -1 : (h == 3) ? 1 : 0;
    endfunction

    function automatic int pick(input logic [3:0] b);
        if (b[1]) return 1;
        if (b[0]) return 0;
        if (b[2]) return 2;
        if (b[3]) return 3;
        return -1;
    endfunction

    task automatic model_reset();
        body = {};
        for (int i = 0; i < 3; i++) body.push_back('{64 - i, 64});
        heading = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_body();
        int ex, ey;
        check("length", bus.length, body.size());
        check("head_x", bus.head_x, body[0].x);
        check("head_y", bus.head_y, body[0].y);
        for (int i = 0; i < MAXL; i++) begin
            bus.rd_idx = 4'(i);
            #1;
            ex = 0;
            ey = 0;
            if (i < body.size()) begin
                ex = body[i].x;
                ey = body[i].y;
            end
            check("rd_x", bus.rd_x, ex);
            check("rd_y", bus.rd_y, ey);
        end
    endtask

    // Called in the first WAIT cycle of a step; returns in the first WAIT cycle
    // of the next step, or in the first OVER cycle (ended = 1).
    task automatic run_step(input bit turns, output bit ended);
        logic [3:0] reqs [3];
        int n, h, p, c, nx, ny, fx, fy, lim, hit, exp_cyc, cyc;
        bit eat, grow, wall;

        n = 0;
        if (turns && $urandom_range(0, 2) == 0) n = $urandom_range(1, 3);
        h = heading;
        p = -1;
        for (int i = 0; i < 3; i++) begin
            reqs[i] = 4'($urandom_range(1, 15));
            if (i < n) begin
                c = pick(reqs[i]);
                if (c >= 0 && c != h && c != (h ^ 1)) p = c;
            end
        end
        if (p >= 0) h = p;
        nx = (body[0].x + dx(h)) & 255;
        ny = (body[0].y + dy(h)) & 255;

        if ($urandom_range(0, 3) != 0) begin
            fx = nx;
            fy = ny;
        end else begin
            fx = $urandom_range(0, 255);
            fy = $urandom_range(0, 255);
        end
        eat  = (nx == fx) && (ny == fy);
        grow = eat && (body.size() < MAXL);
        wall = (nx == 0) || (nx >= GMAX) || (ny == 0) || (ny >= GMAX);
        lim  = grow ? body.size() : body.size() - 1;
        hit  = -1;
        if (!wall) begin
            for (int j = 0; j < lim; j++) begin
                if (hit < 0 && body[j].x == nx && body[j].y == ny) hit = j;
            end
        end
        exp_cyc = wall ? STEP + 1 : (hit >= 0) ? STEP + 2 + hit : STEP + 2 + lim;

        bus.food_x  = 8'(fx);
        bus.food_y  = 8'(fy);
        bus.btn_dir = (n > 0) ? reqs[0] : 4'h0;
        cyc = 0;
        do begin
            tick();
            cyc++;
            bus.btn_dir = 4'h0;
            if (cyc < n) bus.btn_dir = reqs[cyc];
        end while (!bus.step_done && !bus.game_over && cyc < 64);

        check("step_cycles", cyc, exp_cyc);
        if (wall || hit >= 0) begin
            check("over_game_over", bus.game_over, 1);
            check("over_step_done", bus.step_done, 0);
            ended = 1'b1;
        end else begin
            check("step_done", bus.step_done, 1);
            check("food_eaten", bus.food_eaten, eat);
            check("run_game_over", bus.game_over, 0);
            heading = h;
            body.push_front('{nx, ny});
            if (!grow) void'(body.pop_back());
            ended = 1'b0;
        end
        check_body();
    endtask

    // Sits in OVER with random buttons, then restarts; returns in the first WAIT cycle.
    task automatic over_phase();
        int k;
        k = $urandom_range(2, 5);
        for (int i = 0; i < k; i++) begin
            bus.btn_dir = 4'($urandom_range(0, 15));
            tick();
            check("frozen_game_over", bus.game_over, 1);
            check("frozen_step_done", bus.step_done, 0);
        end
        check_body();
        bus.btn_dir = 4'h0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        model_reset();
        check("restart_game_over", bus.game_over, 0);
        check_body();
    endtask

    initial begin
        bit ended;
        int steps;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.btn_dir = 4'h0;
        bus.food_x  = 8'h00;
        bus.food_y  = 8'h00;
        bus.rd_idx  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("rst_game_over", bus.game_over, 0);
        check("rst_step_done", bus.step_done, 0);
        check("rst_food_eaten", bus.food_eaten, 0);
        check_body();
        rst = 1'b0;

        // Buttons in IDLE must not change the initial heading.
        for (int i = 0; i < 4; i++) begin
            bus.btn_dir = 4'($urandom_range(1, 15));
            tick();
            check("idle_step_done", bus.step_done, 0);
        end
        check_body();
        bus.btn_dir = 4'h0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;

        // Game 0 runs straight right with frequent food: grows to the cap, then hits the wall.
        for (int g = 0; g < 12; g++) begin
            ended = 1'b0;
            steps = 0;
            while (!ended && steps < 70) begin
                run_step(g != 0, ended);
                steps++;
            end
            if (ended) over_phase();
        end

        // Reset in the middle of SCAN: step discarded, back to IDLE with the reset body.
        bus.btn_dir = 4'h0;
        repeat (STEP + 1) tick();
        #5 rst = 1'b1;
        #2;
        model_reset();
        check("scanrst_step_done", bus.step_done, 0);
        check_body();
        #4 rst = 1'b0;
        for (int i = 0; i < 3 * STEP; i++) begin
            tick();
            check("idle_after_rst_step_done", bus.step_done, 0);
            check("idle_after_rst_game_over", bus.game_over, 0);
        end
        check_body();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
